// File: rtl/oled_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | oled_pkg                                                             |
// | Opcodes, skip list, addressing modes and parser states for the sink. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package oled_pkg;

  localparam logic [7:0] c_CMD_DISP_OFF  = 8'hAE;
  localparam logic [7:0] c_CMD_DISP_ON   = 8'hAF;
  localparam logic [7:0] c_CMD_CONTRAST  = 8'h81;
  localparam logic [7:0] c_CMD_ADDR_MODE = 8'h20;
  localparam logic [7:0] c_CMD_COL_ADDR  = 8'h21;
  localparam logic [7:0] c_CMD_PAGE_ADDR = 8'h22;

  localparam logic [7:0] c_SKIP_CHARGE_PUMP = 8'h8D;
  localparam logic [7:0] c_SKIP_MUX_RATIO   = 8'hA8;
  localparam logic [7:0] c_SKIP_DISP_OFFSET = 8'hD3;
  localparam logic [7:0] c_SKIP_CLK_DIV     = 8'hD5;
  localparam logic [7:0] c_SKIP_PRECHARGE   = 8'hD9;
  localparam logic [7:0] c_SKIP_COM_PINS    = 8'hDA;
  localparam logic [7:0] c_SKIP_VCOMH       = 8'hDB;

  typedef enum logic [1:0] {
    HORIZ = 2'b00,
    VERT  = 2'b01,
    PAGE  = 2'b10
  } addr_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARG1  = 2'd1,
    ARG2A = 2'd2,
    ARG2B = 2'd3
  } parser_state_t;

  function automatic logic is_skip_cmd(input logic [7:0] op);
    case (op)
      c_SKIP_CHARGE_PUMP, c_SKIP_MUX_RATIO, c_SKIP_DISP_OFFSET, c_SKIP_CLK_DIV,
      c_SKIP_PRECHARGE, c_SKIP_COM_PINS, c_SKIP_VCOMH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_rx_deser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_rx_deser                                                         |
// | Pin synchronizers, sclk edge detect and MSB-first byte assembly.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module spi_rx_deser #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       d_c,
  input  logic       oled_rst,
  output logic [7:0] rx_byte,
  output logic       rx_is_data,
  output logic       rx_valid,
  output logic       oled_rst_sync
);

  logic [SYNC_STAGES-1:0] r_cs_sync, r_sclk_sync, r_mosi_sync, r_dc_sync, r_orst_sync;
  logic                   r_sclk_prev;
  logic [2:0]             r_bit_cnt;
  logic [6:0]             r_shift;
  logic                   w_cs_s, w_sclk_s, w_mosi_s, w_dc_s, w_sclk_rise;

  assign w_cs_s        = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk_s      = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s      = r_mosi_sync[SYNC_STAGES-1];
  assign w_dc_s        = r_dc_sync[SYNC_STAGES-1];
  assign oled_rst_sync = r_orst_sync[SYNC_STAGES-1];
  assign w_sclk_rise   = w_sclk_s & ~r_sclk_prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cs_sync   <= '1;
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_dc_sync   <= '0;
      r_orst_sync <= '1;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_dc_sync   <= {r_dc_sync[SYNC_STAGES-2:0], d_c};
      r_orst_sync <= {r_orst_sync[SYNC_STAGES-2:0], oled_rst};
    end
  end

  // A deselect or a display reset drops any partially shifted byte.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sclk_prev <= 1'b0;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 7'd0;
      rx_byte     <= 8'd0;
      rx_is_data  <= 1'b0;
      rx_valid    <= 1'b0;
    end else begin
      r_sclk_prev <= w_sclk_s;
      rx_valid    <= 1'b0;
      if (w_cs_s || !oled_rst_sync) begin
        r_bit_cnt <= 3'd0;
      end else if (w_sclk_rise) begin
        if (r_bit_cnt == 3'd7) begin
          rx_byte    <= {r_shift, w_mosi_s};
          rx_is_data <= w_dc_s;
          rx_valid   <= 1'b1;
          r_bit_cnt  <= 3'd0;
        end else begin
          r_shift   <= {r_shift[5:0], w_mosi_s};
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/oled_spi_sink.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | oled_spi_sink                                                        |
// | SSD1306-style command parser and GDDRAM pointer fed by spi_rx_deser. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module oled_spi_sink
  import oled_pkg::*;
#(
  parameter int COLS        = 128,
  parameter int PAGES       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cs,
  input  logic                           sclk,
  input  logic                           mosi,
  input  logic                           d_c,
  input  logic                           oled_rst,
  output logic [7:0]                     rx_byte,
  output logic                           rx_is_data,
  output logic                           rx_valid,
  output logic                           pix_we,
  output logic [$clog2(COLS*PAGES)-1:0]  pix_addr,
  output logic [7:0]                     pix_data,
  output logic                           display_on,
  output logic [7:0]                     contrast,
  output logic                           frame_done
);

  localparam int COL_W  = (COLS > 1)  ? $clog2(COLS)  : 1;
  localparam int PAGE_W = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int ADDR_W = $clog2(COLS*PAGES);

  logic                oled_rst_sync;
  parser_state_t       r_state;
  addr_mode_t          r_addr_mode;
  logic [7:0]          r_op;
  logic [COL_W-1:0]    r_col, r_col_start, r_col_end, w_col_end_eff;
  logic [PAGE_W-1:0]   r_page, r_page_start, r_page_end, w_page_end_eff;
  logic [7:0]          w_col8;
  logic                w_col_at_end, w_page_at_end;
  logic [ADDR_W-1:0]   w_addr;

  spi_rx_deser #(.SYNC_STAGES(SYNC_STAGES)) u_deser (
    .clk           (clk),
    .rst           (rst),
    .cs            (cs),
    .sclk          (sclk),
    .mosi          (mosi),
    .d_c           (d_c),
    .oled_rst      (oled_rst),
    .rx_byte       (rx_byte),
    .rx_is_data    (rx_is_data),
    .rx_valid      (rx_valid),
    .oled_rst_sync (oled_rst_sync)
  );

  function automatic logic [COL_W-1:0] clamp_col(input logic [7:0] v);
    if (32'(v) >= COLS) return COL_W'(COLS - 1);
    return v[COL_W-1:0];
  endfunction

  assign w_col_end_eff  = (r_col_end < r_col_start) ? r_col_start : r_col_end;
  assign w_page_end_eff = (r_page_end < r_page_start) ? r_page_start : r_page_end;
  // The physical edge also wraps, so a pointer parked beyond the window cannot run off.
  assign w_col_at_end   = (r_col == w_col_end_eff) || (r_col == COL_W'(COLS - 1));
  assign w_page_at_end  = (r_page == w_page_end_eff) || (r_page == PAGE_W'(PAGES - 1));
  assign w_col8         = 8'(r_col);
  assign w_addr         = ADDR_W'(r_page) * ADDR_W'(COLS) + ADDR_W'(r_col);

  always_ff @(posedge clk) begin
    if (!rst || !oled_rst_sync) begin
      r_state      <= IDLE;
      r_addr_mode  <= PAGE;
      r_op         <= 8'd0;
      r_col        <= '0;
      r_page       <= '0;
      r_col_start  <= '0;
      r_col_end    <= COL_W'(COLS - 1);
      r_page_start <= '0;
      r_page_end   <= PAGE_W'(PAGES - 1);
      display_on   <= 1'b0;
      contrast     <= 8'h7F;
      pix_we       <= 1'b0;
      pix_addr     <= '0;
      pix_data     <= 8'd0;
      frame_done   <= 1'b0;
    end else begin
      pix_we     <= 1'b0;
      frame_done <= 1'b0;
      if (rx_valid && rx_is_data) begin
        r_state  <= IDLE;
        pix_we   <= 1'b1;
        pix_addr <= w_addr;
        pix_data <= rx_byte;
        case (r_addr_mode)
          HORIZ: begin
            if (w_col_at_end) begin
              r_col <= r_col_start;
              if (w_page_at_end) begin
                r_page     <= r_page_start;
                frame_done <= 1'b1;
              end else begin
                r_page <= r_page + PAGE_W'(1);
              end
            end else begin
              r_col <= r_col + COL_W'(1);
            end
          end
          VERT: begin
            if (w_page_at_end) begin
              r_page <= r_page_start;
              if (w_col_at_end) begin
                r_col      <= r_col_start;
                frame_done <= 1'b1;
              end else begin
                r_col <= r_col + COL_W'(1);
              end
            end else begin
              r_page <= r_page + PAGE_W'(1);
            end
          end
          default: r_col <= (r_col == COL_W'(COLS - 1)) ? '0 : r_col + COL_W'(1);
        endcase
      end else if (rx_valid) begin
        case (r_state)
          IDLE: begin
            r_op <= rx_byte;
            if (rx_byte == c_CMD_DISP_OFF) display_on <= 1'b0;
            else if (rx_byte == c_CMD_DISP_ON) display_on <= 1'b1;
            else if (rx_byte == c_CMD_CONTRAST || rx_byte == c_CMD_ADDR_MODE || is_skip_cmd(rx_byte))
              r_state <= ARG1;
            else if (rx_byte == c_CMD_COL_ADDR || rx_byte == c_CMD_PAGE_ADDR)
              r_state <= ARG2A;
            else if (rx_byte[7:3] == 5'b10110) r_page <= rx_byte[PAGE_W-1:0];
            else if (rx_byte[7:4] == 4'h0) r_col <= clamp_col({w_col8[7:4], rx_byte[3:0]});
            else if (rx_byte[7:4] == 4'h1) r_col <= clamp_col({rx_byte[3:0], w_col8[3:0]});
          end
          ARG1: begin
            r_state <= IDLE;
            if (r_op == c_CMD_CONTRAST) contrast <= rx_byte;
            else if (r_op == c_CMD_ADDR_MODE) begin
              case (rx_byte[1:0])
                2'b00:   r_addr_mode <= HORIZ;
                2'b01:   r_addr_mode <= VERT;
                default: r_addr_mode <= PAGE;
              endcase
            end
          end
          ARG2A: begin
            r_state <= ARG2B;
            if (r_op == c_CMD_COL_ADDR) begin
              r_col_start <= clamp_col(rx_byte);
              r_col       <= clamp_col(rx_byte);
            end else begin
              r_page_start <= rx_byte[PAGE_W-1:0];
              r_page       <= rx_byte[PAGE_W-1:0];
            end
          end
          default: begin
            r_state <= IDLE;
            if (r_op == c_CMD_COL_ADDR) r_col_end <= clamp_col(rx_byte);
            else r_page_end <= rx_byte[PAGE_W-1:0];
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_oled_spi_sink.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_oled_spi_sink                                                     |
// | Directed SPI stimulus with queued expectations and an output monitor.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_oled_spi_sink;

  localparam int COLS = 128, PAGES = 4, SYNC_STAGES = 2;
  localparam int ADDR_W = $clog2(COLS*PAGES);

  logic clk = 1'b0, rst = 1'b0, cs = 1'b1, sclk = 1'b0, mosi = 1'b0, d_c = 1'b0, oled_rst = 1'b1;
  logic [7:0] rx_byte, pix_data, contrast;
  logic rx_is_data, rx_valid, pix_we, display_on, frame_done;
  logic [ADDR_W-1:0] pix_addr;

  typedef struct packed { logic [7:0] b; logic d; } rx_exp_t;
  typedef struct packed { logic [ADDR_W-1:0] a; logic [7:0] d; logic fd; } pix_exp_t;
  rx_exp_t  rx_q[$];
  pix_exp_t pix_q[$];
  int n_cmp = 0, n_fail = 0;

  oled_spi_sink #(.COLS(COLS), .PAGES(PAGES), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .mosi(mosi), .d_c(d_c), .oled_rst(oled_rst),
    .rx_byte(rx_byte), .rx_is_data(rx_is_data), .rx_valid(rx_valid),
    .pix_we(pix_we), .pix_addr(pix_addr), .pix_data(pix_data),
    .display_on(display_on), .contrast(contrast), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents a byte or a pixel write.
  always @(negedge clk) begin : mon
    rx_exp_t  er;
    pix_exp_t ep;
    if (rx_valid) begin
      if (rx_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL rx_unexpected: got byte 0x%0h expected none", rx_byte);
      end else begin
        er = rx_q.pop_front();
        check("rx_byte", 32'(rx_byte), 32'(er.b));
        check("rx_is_data", 32'(rx_is_data), 32'(er.d));
      end
    end
    if (pix_we) begin
      if (pix_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL pix_unexpected: got addr 0x%0h expected none", pix_addr);
      end else begin
        ep = pix_q.pop_front();
        check("pix_addr", 32'(pix_addr), 32'(ep.a));
        check("pix_data", 32'(pix_data), 32'(ep.d));
        check("frame_done", 32'(frame_done), 32'(ep.fd));
      end
    end else if (frame_done) begin
      n_cmp++; n_fail++;
      $display("FAIL frame_done_stray: got 1 expected 0 without pix_we");
    end
  end

  task automatic shift_bit(input logic b, input logic dc);
    mosi = b; d_c = dc;
    #40 sclk = 1'b1;
    #40 sclk = 1'b0;
  endtask

  task automatic shift_byte(input logic [7:0] b, input logic dc);
    for (int i = 7; i >= 0; i--) shift_bit(b[i], dc);
  endtask

  task automatic send(input logic [7:0] b, input logic dc);
    rx_q.push_back('{b: b, d: dc});
    cs = 1'b0;
    #40;
    shift_byte(b, dc);
    #40 cs = 1'b1;
    #40;
  endtask

  task automatic expect_pix(input logic [ADDR_W-1:0] a, input logic [7:0] d, input logic fd);
    pix_q.push_back('{a: a, d: d, fd: fd});
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_rx_byte", 32'(rx_byte), 32'h0);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_pix_we", 32'(pix_we), 32'h0);
    check("rst_pix_addr", 32'(pix_addr), 32'h0);
    check("rst_display_on", 32'(display_on), 32'h0);
    check("rst_contrast", 32'(contrast), 32'h7F);
    check("rst_frame_done", 32'(frame_done), 32'h0);

    // Display on and contrast, no pixel writes
    send(8'hAF, 1'b0); send(8'h81, 1'b0); send(8'h40, 1'b0);
    #100;
    check("t1_display_on", 32'(display_on), 32'h1);
    check("t1_contrast", 32'(contrast), 32'h40);

    // Page mode pointer via B2 / low nibble / high nibble
    send(8'hB2, 1'b0); send(8'h05, 1'b0); send(8'h13, 1'b0);
    expect_pix(9'h135, 8'hA5, 1'b0);
    send(8'hA5, 1'b1);

    // Horizontal window 7E..7F x 0..1, wrap with frame_done
    send(8'h20, 1'b0); send(8'h00, 1'b0);
    send(8'h21, 1'b0); send(8'h7E, 1'b0); send(8'h7F, 1'b0);
    send(8'h22, 1'b0); send(8'h00, 1'b0); send(8'h01, 1'b0);
    expect_pix(9'h07E, 8'h01, 1'b0);
    expect_pix(9'h07F, 8'h02, 1'b0);
    expect_pix(9'h0FE, 8'h03, 1'b0);
    expect_pix(9'h0FF, 8'h04, 1'b1);
    expect_pix(9'h07E, 8'h05, 1'b0);
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);

    // Aborted partial byte then a whole one
    cs = 1'b0; #40;
    for (int i = 0; i < 5; i++) shift_bit(1'b1, 1'b0);
    #40 cs = 1'b1; #80;
    send(8'h3C, 1'b0);
    #100;
    check("t4_rx_byte", 32'(rx_byte), 32'h3C);

    // Display reset mid-byte
    cs = 1'b0; #40;
    for (int i = 0; i < 3; i++) shift_bit(1'b1, 1'b0);
    oled_rst = 1'b0;
    #200;
    check("t6_display_on", 32'(display_on), 32'h0);
    check("t6_contrast", 32'(contrast), 32'h7F);
    check("t6_pix_addr", 32'(pix_addr), 32'h0);
    oled_rst = 1'b1;
    #100;
    rx_q.push_back('{b: 8'hAF, d: 1'b0});
    shift_byte(8'hAF, 1'b0);
    #40 cs = 1'b1; #100;
    check("t6_display_on_after", 32'(display_on), 32'h1);

    // Data abandons a pending argument
    send(8'h81, 1'b0);
    expect_pix(9'h000, 8'h11, 1'b0);
    send(8'h11, 1'b1);
    #100;
    check("t5_contrast_kept", 32'(contrast), 32'h7F);
    send(8'h81, 1'b0); send(8'h22, 1'b0);
    #100;
    check("t5_contrast_new", 32'(contrast), 32'h22);

    // Clamp, truncate and end-below-start
    send(8'h20, 1'b0); send(8'h00, 1'b0);
    send(8'h21, 1'b0); send(8'h90, 1'b0); send(8'h05, 1'b0);
    send(8'h22, 1'b0); send(8'h06, 1'b0); send(8'h00, 1'b0);
    expect_pix(9'h17F, 8'h55, 1'b1);
    expect_pix(9'h17F, 8'h66, 1'b1);
    send(8'h55, 1'b1); send(8'h66, 1'b1);

    #500;
    check("rx_q_drained", 32'(rx_q.size()), 32'h0);
    check("pix_q_drained", 32'(pix_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
